// File: rtl/dmem_port_arbiter_pkg.sv
// rtl/dmem_port_arbiter_pkg.sv - shared defaults, port ids and FSM states for the data-memory arbiter
package dmem_port_arbiter_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int ADDR_W_DEF     = 32;
    localparam int DEPTH_LOG2_DEF = 10;
    localparam int LOCK_MAX_DEF   = 8;

    localparam logic P_CPU = 1'b0;
    localparam logic P_LDR = 1'b1;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant; pointer moves past whichever port the caller granted
module rr_arbiter2
    import dmem_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       adv_port,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (ptr == P_LDR) ? 2'b10 : 2'b01;
        end
    end

    // The final grant may come from the lock FSM rather than gnt, so the caller says who won.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= P_CPU;
        end else if (advance) begin
            ptr <= ~adv_port;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - CPU/loader data-memory port arbiter with bounded loader lock
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int LOCK_MAX   = LOCK_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_W-1:0]     p0_addr,
    input  logic [DATA_W-1:0]     p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_W-1:0]     p0_rdata,
    output logic                  p0_err,
    output logic                  cpu_stall,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_W-1:0]     p1_addr,
    input  logic [DATA_W-1:0]     p1_wdata,
    input  logic                  p1_lock,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_W-1:0]     p1_rdata,
    output logic                  p1_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    arb_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [1:0]        rr_gnt, gnt;
    logic              sel, g_we, legal;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic              rsp_valid, rsp_port, rsp_err;

    rr_arbiter2 u_rr (
        .clk      (clk),
        .reset    (reset),
        .req      ({p1_req, p0_req}),
        .advance  (|gnt),
        .adv_port (gnt[1]),
        .gnt      (rr_gnt)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt       = 2'b00;
        case (state)
            ST_ARB: begin
                gnt = rr_gnt;
                if (rr_gnt[1] && p1_lock) begin
                    state_nxt = ST_LOCKED;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            ST_LOCKED: begin
                // At the cap the loader keeps going only while the CPU is not waiting.
                if (p1_req && p1_lock && ((cnt < CNT_MAX) || !p0_req)) begin
                    gnt = 2'b10;
                    if (cnt < CNT_MAX) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else begin
                    state_nxt = ST_ARB;
                    cnt_nxt   = '0;
                    gnt       = ((cnt == CNT_MAX) && p0_req) ? 2'b01 : rr_gnt;
                end
            end
            default: state_nxt = ST_ARB;
        endcase
        if (!reset) begin
            gnt = 2'b00;
        end
    end

    assign sel     = gnt[1];
    assign g_addr  = sel ? p1_addr  : p0_addr;
    assign g_we    = sel ? p1_we    : p0_we;
    assign g_wdata = sel ? p1_wdata : p0_wdata;
    assign legal   = (g_addr[1:0] == 2'b00) && (g_addr[ADDR_W-1:DEPTH_LOG2+2] == '0);

    assign p0_gnt    = gnt[0];
    assign p1_gnt    = gnt[1];
    assign cpu_stall = reset & p0_req & ~gnt[0];

    assign mem_en    = (|gnt) & legal;
    assign mem_we    = mem_en & g_we;
    assign mem_addr  = mem_en ? g_addr[DEPTH_LOG2+1:2] : '0;
    assign mem_wdata = mem_we ? g_wdata : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_ARB;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_port  <= P_CPU;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            // Legal writes are posted; everything else answers one cycle after grant.
            rsp_valid <= (|gnt) & (~legal | ~g_we);
            rsp_port  <= sel;
            rsp_err   <= (|gnt) & ~legal;
        end
    end

    assign p0_rvalid = rsp_valid & (rsp_port == P_CPU);
    assign p1_rvalid = rsp_valid & (rsp_port == P_LDR);
    assign p0_err    = p0_rvalid & rsp_err;
    assign p1_err    = p1_rvalid & rsp_err;
    assign p0_rdata  = (p0_rvalid & ~rsp_err) ? mem_rdata : '0;
    assign p1_rdata  = (p1_rvalid & ~rsp_err) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - scoreboard bench for dmem_port_arbiter with reference arbitration model
module tb_dmem_port_arbiter;

    localparam int DEPTH    = 1024;
    localparam int LOCK_MAX = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
    logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
    logic        p0_gnt, p0_rvalid, p0_err, cpu_stall, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    dmem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .cpu_stall(cpu_stall),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_lock(p1_lock),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous single-port memory the arbiter drives.
    logic [31:0] emu_mem [DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) emu_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= emu_mem[mem_addr];
        end
    end

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t        q0[$];
    rsp_t        q1[$];
    logic [31:0] ref_mem [DEPTH];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          m_prio = 0;
    int          m_run = 0;
    bit          m_locked = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: which port the rules award this cycle, plus what it should do to memory.
    always @(negedge clk) begin : grant_chk
        int          g;
        bit          decided, legal, we;
        logic [31:0] a, wd;
        logic [1:0]  eg;
        rsp_t        r;
        if (!reset) begin
            check("reset_outputs", {p0_gnt, p0_rvalid, p0_err, cpu_stall, p1_gnt, p1_rvalid, p1_err, mem_en, mem_we}, 0);
            check("reset_data", p0_rdata | p1_rdata | mem_wdata | {22'b0, mem_addr}, 0);
            m_prio = 0; m_run = 0; m_locked = 1'b0;
            q0.delete(); q1.delete();
        end else begin
            g = -1;
            decided = 1'b0;
            if (m_locked) begin
                if (p1_req && p1_lock && (m_run < LOCK_MAX || !p0_req)) begin
                    g = 1; decided = 1'b1;
                    if (m_run < LOCK_MAX) m_run++;
                end else begin
                    if (m_run == LOCK_MAX && p0_req) begin
                        g = 0; decided = 1'b1;
                    end
                    m_locked = 1'b0; m_run = 0;
                end
            end
            if (!decided) begin
                if (p0_req && p1_req) g = m_prio;
                else if (p0_req)      g = 0;
                else if (p1_req)      g = 1;
                if (g == 1 && p1_lock) begin
                    m_locked = 1'b1; m_run = 1;
                end
            end
            eg = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
            check("gnt", {p1_gnt, p0_gnt}, eg);
            check("cpu_stall", cpu_stall, p0_req && g != 0);
            if (g >= 0) begin
                m_prio = 1 - g;
                a  = (g == 1) ? p1_addr  : p0_addr;
                we = (g == 1) ? p1_we    : p0_we;
                wd = (g == 1) ? p1_wdata : p0_wdata;
                legal = (a % 4 == 0) && (a / 4 < DEPTH);
                check("mem_en", mem_en, legal);
                r.due = cyc + 1; r.err = 1'b0; r.data = '0;
                if (legal) begin
                    check("mem_we", mem_we, we);
                    check("mem_addr", mem_addr, a / 4);
                    if (we) begin
                        check("mem_wdata", mem_wdata, wd);
                        ref_mem[a / 4] = wd;
                    end else begin
                        r.data = ref_mem[a / 4];
                    end
                end else begin
                    r.err = 1'b1;
                end
                if (!legal || !we) begin
                    if (g == 1) q1.push_back(r);
                    else        q0.push_back(r);
                end
            end else begin
                check("mem_en_idle", mem_en, 0);
            end
        end
    end

    task automatic mon(input int p, input logic rv, input logic er, input logic [31:0] rd);
        rsp_t e;
        bit   have;
        have = 1'b0;
        if (p == 0 && q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1'b1; end
        if (p == 1 && q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1'b1; end
        check(p == 0 ? "p0_rvalid" : "p1_rvalid", rv, have);
        if (have && rv) begin
            check(p == 0 ? "p0_err" : "p1_err", er, e.err);
            check(p == 0 ? "p0_rdata" : "p1_rdata", rd, e.data);
        end
    endtask

    always @(negedge clk) begin : rsp_mon
        if (reset) begin
            mon(0, p0_rvalid, p0_err, p0_rdata);
            mon(1, p1_rvalid, p1_err, p1_rdata);
        end
    end

    task automatic set_p0(input logic rq, input logic w, input logic [31:0] a, input logic [31:0] d);
        p0_req = rq; p0_we = w; p0_addr = a; p0_wdata = d;
    endtask

    task automatic set_p1(input logic rq, input logic w, input logic [31:0] a, input logic [31:0] d, input logic l);
        p1_req = rq; p1_we = w; p1_addr = a; p1_wdata = d; p1_lock = l;
    endtask

    task automatic tick(output logic g0, output logic g1);
        @(negedge clk);
        g0 = p0_gnt; g1 = p1_gnt;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r < 14)      return 32'($urandom_range(0, 15) * 4);
        else if (r < 16) return 32'h0000_0FFC;
        else if (r < 18) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        else             return 32'h0000_1000 + 32'($urandom_range(0, 255) * 4);
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic g0, g1, pg0;
        int   cnt, viol, p1_before, stall, p1_done;
        bit   p0_pend, p0_done, pend0, pend1;

        for (int i = 0; i < DEPTH; i++) begin
            emu_mem[i] = 32'(i) * 32'h9E37_79B9;
            ref_mem[i] = 32'(i) * 32'h9E37_79B9;
        end

        // Reset with a CPU request pending: everything must stay quiet.
        set_p0(1, 0, 32'h10, 0);
        repeat (3) @(posedge clk);
        #1 set_p0(0, 0, 0, 0);
        reset = 1'b1;
        tick(g0, g1);

        // CPU alone: write then read the same word back to back.
        set_p0(1, 1, 32'h10, 32'hDEAD_BEEF);
        tick(g0, g1);
        check("t2_write_gnt", g0, 1);
        set_p0(1, 0, 32'h10, 0);
        tick(g0, g1);
        check("t2_read_gnt", g0, 1);
        set_p0(0, 0, 0, 0);
        @(negedge clk);
        check("t2_rvalid", p0_rvalid, 1);
        check("t2_rdata", p0_rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // Reset lands between a read grant and its response.
        set_p0(1, 0, 32'h10, 0);
        @(negedge clk);
        check("t1_read_gnt", p0_gnt, 1);
        #1 reset = 1'b0;
        set_p0(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (p0_rvalid) cnt++;
            @(posedge clk); #1;
        end
        check("t1_no_rvalid_after_reset", cnt, 0);

        // Contention without lock: grants must alternate.
        viol = 0; cnt = 0; pg0 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            set_p0(1, 0, 32'(k * 4), 0);
            set_p1(1, 1, 32'(64 + k * 4), 32'($urandom), 0);
            tick(g0, g1);
            if (k > 0 && g0 == pg0) viol++;
            if (g0) cnt++;
            pg0 = g0;
        end
        check("t3_alternation_errors", viol, 0);
        check("t3_p0_grants", cnt, 5);
        set_p0(0, 0, 0, 0); set_p1(0, 0, 0, 0, 0);
        repeat (2) tick(g0, g1);

        // Locked loader burst; CPU arrives on burst cycle 2.
        p1_done = 0; p1_before = 0; stall = 0; p0_pend = 0; p0_done = 0;
        for (int k = 0; k < 60 && p1_done < 20; k++) begin
            set_p1(1, 1, 32'h100 + 32'(p1_done * 4), 32'($urandom), 1);
            if (k == 2) p0_pend = 1'b1;
            set_p0(p0_pend, 0, 32'h100, 0);
            @(negedge clk);
            if (p1_gnt) begin
                p1_done++;
                if (!p0_done) p1_before++;
            end
            if (cpu_stall) stall++;
            if (p0_gnt) begin p0_pend = 1'b0; p0_done = 1'b1; end
            @(posedge clk); #1;
        end
        check("t4_p1_grants_before_cpu", p1_before, LOCK_MAX);
        check("t4_cpu_stall_cycles", stall, 6);
        check("t4_cpu_served", p0_done, 1);
        check("t4_burst_complete", p1_done, 20);
        set_p0(0, 0, 0, 0); set_p1(0, 0, 0, 0, 0);
        repeat (2) tick(g0, g1);

        // Illegal accesses: misaligned CPU read, out-of-range loader write.
        set_p0(1, 0, 32'h3, 0);
        @(negedge clk);
        check("t5_misaligned_mem_en", mem_en, 0);
        @(posedge clk); #1;
        set_p0(0, 0, 0, 0);
        set_p1(1, 1, 32'h1000, 32'h0BAD_0BAD, 0);
        @(negedge clk);
        check("t5_misaligned_rvalid", p0_rvalid, 1);
        check("t5_misaligned_err", p0_err, 1);
        check("t5_range_mem_en", mem_en, 0);
        @(posedge clk); #1;
        set_p1(1, 0, 32'h0, 0, 0);
        @(negedge clk);
        check("t5_range_err", p1_err, 1);
        @(posedge clk); #1;
        set_p1(0, 0, 0, 0, 0);
        @(negedge clk);
        check("t5_word0_unchanged", p1_rdata, ref_mem[0]);
        @(posedge clk); #1;

        // Idle cycles leave the pointer alone.
        set_p1(1, 0, 32'h20, 0, 0);
        tick(g0, g1);
        check("t6_p1_alone_gnt", g1, 1);
        set_p1(0, 0, 0, 0, 0);
        repeat (3) tick(g0, g1);
        set_p0(1, 0, 32'h24, 0); set_p1(1, 0, 32'h28, 0, 0);
        tick(g0, g1);
        check("t6_p0_first", {g1, g0}, 2'b01);
        set_p0(0, 0, 0, 0); set_p1(0, 0, 0, 0, 0);
        repeat (2) tick(g0, g1);

        // Randomized traffic; requesters hold until granted.
        pend0 = 0; pend1 = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!pend0 && $urandom_range(0, 99) < 50) begin
                set_p0(1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
                pend0 = 1;
            end
            if (!pend1 && $urandom_range(0, 99) < 60) begin
                set_p1(1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom, $urandom_range(0, 99) < 40);
                pend1 = 1;
            end
            if (i == 1500) reset = 1'b0;
            if (i == 1502) reset = 1'b1;
            tick(g0, g1);
            if (g0) begin pend0 = 0; set_p0(0, 0, 0, 0); end
            if (g1) begin pend1 = 0; set_p1(0, 0, 0, 0, 0); end
        end
        set_p0(0, 0, 0, 0); set_p1(0, 0, 0, 0, 0);
        repeat (3) tick(g0, g1);
        check("queues_drained", q0.size() + q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
